// File: rtl/rippling_led_monitor_pkg.sv
// Shared state and error encodings for the rippling LED bus monitor.
// The monitor and its encoder import this package.
package rippling_led_monitor_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StSync  = 2'b01,
      StTrack = 2'b10,
      StErr   = 2'b11
   } mon_state_e;

   typedef enum logic [1:0] {
      ErrNone   = 2'b00,
      ErrOnehot = 2'b01,
      ErrStep   = 2'b10,
      ErrDwell  = 2'b11
   } err_code_e;

   typedef enum logic {
      DirLeft  = 1'b0,
      DirRight = 1'b1
   } dir_e;

   localparam int unsigned StepCntW = 16;

endpackage

// File: rtl/rippling_led_monitor_onehot_to_pos.sv
// Combinational bus-to-index encoder with a one-hot flag.
// The index is only meaningful when onehot_o is set; all-zero counts as not one-hot.
module rippling_led_monitor_onehot_to_pos #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]         vec_i,
   output logic [$clog2(WIDTH)-1:0] idx_o,
   output logic                     onehot_o
);

   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   always_comb begin
      idx_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) begin
            idx_o = idx_o | IdxW'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves zero only for a single set bit.
   assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - One)) == '0);

endmodule

// File: rtl/rippling_led_monitor.sv
// Receive-side checker for the rippling LED bus: locks onto the lit position and flags errors.
// Build option RIPPLE_MON_BIDIR_EN: accept right-rippling streams, direction learned on lock.
module rippling_led_monitor
   import rippling_led_monitor_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DWELL_MIN = 4,
   parameter int unsigned DWELL_MAX = 50000000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         led_in,
   input  logic                     clr,
   output logic                     locked,
   output logic                     step_pulse,
   output logic                     err_pulse,
   output logic [1:0]               err_code,
   output logic                     err_sticky,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic [StepCntW-1:0]      step_count
);

   localparam int unsigned PosW = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] DwellMin = CNT_W'(DWELL_MIN);
   localparam logic [CNT_W-1:0] DwellMax = CNT_W'(DWELL_MAX);
   localparam logic [CNT_W-1:0] DwellOne = CNT_W'(1);
   localparam logic [PosW-1:0]  PosOne   = PosW'(1);

   logic [WIDTH-1:0]    sync1_q, s_q, p_q;
   logic [CNT_W-1:0]    dwell_q, dwell_d;
   mon_state_e          state_q, state_d;
   logic [PosW-1:0]     pos_q, pos_d;
   logic [StepCntW-1:0] step_cnt_q, step_cnt_d;
   err_code_e           err_code_q, err_code_d;
   logic                err_sticky_q, err_sticky_d;
   logic                step_pulse_q, err_pulse_q;

   logic                s_change;
   logic                s_onehot;
   logic [PosW-1:0]     s_idx;
   logic [PosW-1:0]     pos_left;
   logic [PosW-1:0]     pos_exp;
   logic                dwell_short, dwell_long;
   logic                step_hit, err_hit;
   err_code_e           err_kind;

`ifdef RIPPLE_MON_BIDIR_EN
   dir_e                dir_q, dir_d;
   logic [PosW-1:0]     pos_right;
`endif

   rippling_led_monitor_onehot_to_pos #(
      .WIDTH (WIDTH)
   ) u_enc (
      .vec_i    (s_q),
      .idx_o    (s_idx),
      .onehot_o (s_onehot)
   );

   assign s_change    = (s_q != p_q);
   assign pos_left    = pos_q + PosOne;
   assign dwell_short = (dwell_q < DwellMin);
   assign dwell_long  = (dwell_q > DwellMax);

`ifdef RIPPLE_MON_BIDIR_EN
   assign pos_right = pos_q - PosOne;
   assign pos_exp   = (dir_q == DirRight) ? pos_right : pos_left;
`else
   assign pos_exp   = pos_left;
`endif

   // dwell_q counts how long the current s has been stable; on a change it holds the old dwell.
   always_comb begin
      if (s_change) begin
         dwell_d = DwellOne;
      end else if (&dwell_q) begin
         dwell_d = dwell_q;
      end else begin
         dwell_d = dwell_q + DwellOne;
      end
   end

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      step_cnt_d   = step_cnt_q;
      err_code_d   = err_code_q;
      err_sticky_d = err_sticky_q;
      step_hit     = 1'b0;
      err_hit      = 1'b0;
      err_kind     = ErrNone;
`ifdef RIPPLE_MON_BIDIR_EN
      dir_d        = dir_q;
`endif

      unique case (state_q)
         StIdle, StErr: begin
            if (s_onehot) begin
               state_d = StSync;
               pos_d   = s_idx;
            end
         end

         StSync: begin
            if (s_change) begin
               if (!s_onehot) begin
                  err_hit  = 1'b1;
                  err_kind = ErrOnehot;
               end else if (s_idx == pos_left) begin
                  step_hit = 1'b1;
`ifdef RIPPLE_MON_BIDIR_EN
                  dir_d    = DirLeft;
               end else if (s_idx == pos_right) begin
                  step_hit = 1'b1;
                  dir_d    = DirRight;
`endif
               end else begin
                  err_hit  = 1'b1;
                  err_kind = ErrStep;
               end
            end
         end

         StTrack: begin
            if (s_change) begin
               if (!s_onehot) begin
                  err_hit  = 1'b1;
                  err_kind = ErrOnehot;
               end else if (s_idx != pos_exp) begin
                  err_hit  = 1'b1;
                  err_kind = ErrStep;
               end else if (dwell_short || dwell_long) begin
                  err_hit  = 1'b1;
                  err_kind = ErrDwell;
               end else begin
                  step_hit = 1'b1;
               end
            end else if (dwell_long) begin
               // Stalled bus.
               err_hit  = 1'b1;
               err_kind = ErrDwell;
            end
         end

         default: state_d = StIdle;
      endcase

      if (step_hit) begin
         state_d    = StTrack;
         pos_d      = s_idx;
         step_cnt_d = step_cnt_q + 16'd1;
      end

      if (err_hit) begin
         state_d      = StErr;
         err_code_d   = err_kind;
         err_sticky_d = 1'b1;
      end

      // Clear beats a same-cycle step or error for the counter and sticky flag only.
      if (clr) begin
         step_cnt_d   = '0;
         err_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         s_q          <= '0;
         p_q          <= '0;
         dwell_q      <= DwellOne;
         state_q      <= StIdle;
         pos_q        <= '0;
         step_cnt_q   <= '0;
         err_code_q   <= ErrNone;
         err_sticky_q <= 1'b0;
         step_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         sync1_q      <= led_in;
         s_q          <= sync1_q;
         p_q          <= s_q;
         dwell_q      <= dwell_d;
         state_q      <= state_d;
         pos_q        <= pos_d;
         step_cnt_q   <= step_cnt_d;
         err_code_q   <= err_code_d;
         err_sticky_q <= err_sticky_d;
         step_pulse_q <= step_hit;
         err_pulse_q  <= err_hit;
      end
   end

`ifdef RIPPLE_MON_BIDIR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dir_q <= DirLeft;
      end else begin
         dir_q <= dir_d;
      end
   end
`endif

   assign locked     = (state_q == StTrack);
   assign step_pulse = step_pulse_q;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign err_sticky = err_sticky_q;
   assign pos        = pos_q;
   assign step_count = step_cnt_q;

endmodule
